ext_share_arbiter: RTL

//  Shares one combinational Extender instance between two requesters (e.g. ALU-immediate path, branch-offset path).

---
 rtl/ext_share_arbiter.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/ext_share_arbiter.sv
// ext_share_arbiter
//   Shares one combinational Extender between two requesters. A granted
//   operand and mode are registered onto the Extender inputs, held for
//   SETTLE_CYCLES edges, and then the Extender output is captured into
//   `result`. A one-cycle done pulse goes to the granted requester.
//
// Parameters
//   WIDTH          operand/result width (matches Extender X_in/X_out)
//   SETTLE_CYCLES  edges the Extender inputs are held before capture (>= 1)
//
// Ports
//   clk, rst_n      rising-edge clock, synchronous active-low reset
//   req0/x0/mode0   requester 0 request, operand, ZE_SE (1 = sign-extend)
//   req1/x1/mode1   requester 1 request, operand, ZE_SE
//   done0, done1    one-cycle result-valid pulses (never both high)
//   result          captured Extender output, held until the next capture
//   busy            high while an operation is in flight (SETTLE or RESP)
//   ext_x_in        registered drive to Extender X_in
//   ext_ze_se       registered drive to Extender ZE_SE
//   ext_x_out       Extender X_out
//
// Configuration
//   EXT_ARB_FIXED_PRIO_EN  when defined, req0 always wins a tie (req1 can
//                          starve); otherwise ties alternate round-robin.

module ext_share_arbiter #(
    parameter int WIDTH         = 32,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic [WIDTH-1:0] x0,
    input  logic             mode0,
    input  logic             req1,
    input  logic [WIDTH-1:0] x1,
    input  logic             mode1,
    output logic             done0,
    output logic             done1,
    output logic [WIDTH-1:0] result,
    output logic             busy,
    output logic [WIDTH-1:0] ext_x_in,
    output logic             ext_ze_se,
    input  logic [WIDTH-1:0] ext_x_out
);

    localparam int CNT_W = $clog2(SETTLE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t           state_r, state_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic             last_r, last_s;
    logic [WIDTH-1:0] ext_x_in_r, ext_x_in_s;
    logic             ext_ze_se_r, ext_ze_se_s;
    logic [WIDTH-1:0] result_r, result_s;
    logic             done0_r, done0_s;
    logic             done1_r, done1_s;
    logic             busy_r, busy_s;
    logic             grant_s;

    // Arbitration: a lone request wins; a tie goes to the requester not served last
    // (or always to requester 0 in the fixed-priority build).
    always_comb begin
        grant_s = 1'b0;
        if (req0 && req1) begin
`ifdef EXT_ARB_FIXED_PRIO_EN
            grant_s = 1'b0;
`else
            grant_s = ~last_r;
`endif
        end else if (req1) begin
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end
    end

    // Next-state and next-output logic; every register holds unless changed.
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        last_s      = last_r;
        ext_x_in_s  = ext_x_in_r;
        ext_ze_se_s = ext_ze_se_r;
        result_s    = result_r;
        done0_s     = 1'b0;
        done1_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (req0 || req1) begin
                    ext_x_in_s  = grant_s ? x1 : x0;
                    ext_ze_se_s = grant_s ? mode1 : mode0;
                    last_s      = grant_s;
                    cnt_s       = CNT_LOAD;
                    state_s     = ST_SETTLE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                // last_r identifies the requester owning the in-flight operation.
                if (cnt_r == CNT_ZERO) begin
                    result_s = ext_x_out;
                    done0_s  = ~last_r;
                    done1_s  = last_r;
                    state_s  = ST_RESP;
                end else begin
                    cnt_s = cnt_r - CNT_ONE;
                end
            end
            ST_RESP: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
        busy_s = (state_s != ST_IDLE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            cnt_r       <= CNT_ZERO;
            last_r      <= 1'b1;
            ext_x_in_r  <= {WIDTH{1'b0}};
            ext_ze_se_r <= 1'b0;
            result_r    <= {WIDTH{1'b0}};
            done0_r     <= 1'b0;
            done1_r     <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            last_r      <= last_s;
            ext_x_in_r  <= ext_x_in_s;
            ext_ze_se_r <= ext_ze_se_s;
            result_r    <= result_s;
            done0_r     <= done0_s;
            done1_r     <= done1_s;
            busy_r      <= busy_s;
        end
    end

    assign done0     = done0_r;
    assign done1     = done1_r;
    assign result    = result_r;
    assign busy      = busy_r;
    assign ext_x_in  = ext_x_in_r;
    assign ext_ze_se = ext_ze_se_r;

endmodule
